// File: rtl/bcd_tx_pkg.sv
// bcd_tx_pkg: shared types and constants for the BCD-to-ASCII frame transmitter.
//   state_t    : controller states (IDLE, DIGIT, SEP, CR, LF, DONE)
//   ASCII_*    : fixed character codes used by the transmitter
package bcd_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIGIT = 3'd1,
    SEP   = 3'd2,
    CR    = 3'd3,
    LF    = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/bcd_to_ascii.sv
// bcd_to_ascii: combinational BCD nibble to ASCII character.
//   nibble  in  4  BCD digit
//   ascii   out 8  '0'..'9', or '?' when the digit is not valid BCD
//   invalid out 1  high when nibble > 9
module bcd_to_ascii
  import bcd_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii,
  output logic       invalid
);

  assign invalid = (nibble > 4'd9);
  assign ascii   = invalid ? ASCII_ERR : (ASCII_ZERO + {4'h0, nibble});

endmodule

// File: rtl/bcd_ascii_frame_tx.sv
// bcd_ascii_frame_tx: snapshots NDIG BCD digits on a start pulse and writes one
// ASCII character per cycle into a downstream byte FIFO, most significant digit
// first, with SEP_CHAR inserted after every digit k (k != 0) whose DP_MASK bit
// is set.
//
// Optional feature: define BCD_TX_CRLF_EN to end every frame with CR, LF.
//
// Ports:
//   i_clk        in  1       clock, rising edge
//   i_reset      in  1       synchronous active-high reset
//   i_start      in  1       frame request, accepted in IDLE or DONE only
//   i_digits     in  4*NDIG  BCD digits, digit k at [4k+3:4k]
//   i_fifo_full  in  1       downstream FIFO full
//   o_ascii      out 8       character presented to the FIFO (0 when not emitting)
//   o_fifo_wr    out 1       FIFO write strobe
//   o_busy       out 1       frame in progress
//   o_done       out 1       one-cycle pulse after the last write
//   o_err        out 1       sticky: invalid digit seen in the current frame
//   o_state      out 3       controller state (debug visibility)
//
// FIFO handshake: o_fifo_wr acts as valid and ~i_fifo_full as ready; o_fifo_wr
// already includes ~i_fifo_full, so every cycle with o_fifo_wr high is a
// transfer. o_ascii is held stable until that transfer happens.
module bcd_ascii_frame_tx
  import bcd_tx_pkg::*;
#(
  parameter int               NDIG     = 4,
  parameter logic [NDIG-1:0]  DP_MASK  = 4'b1010,
  parameter logic [7:0]       SEP_CHAR = 8'h2E
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [4*NDIG-1:0] i_digits,
  input  logic              i_fifo_full,
  output logic [7:0]        o_ascii,
  output logic              o_fifo_wr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [4*NDIG-1:0]   dig_q;
  logic                err_q;

  logic [3:0]          cur_nib;
  logic [7:0]          dig_char;
  logic                dig_bad;
  logic                emitting;

  // Single converter on the digit currently addressed by idx.
  assign cur_nib = dig_q[{idx, 2'b00} +: 4];

  bcd_to_ascii u_conv (
    .nibble  (cur_nib),
    .ascii   (dig_char),
    .invalid (dig_bad)
  );

`ifdef BCD_TX_CRLF_EN
  assign emitting = (state == DIGIT) || (state == SEP) || (state == CR) || (state == LF);
`else
  assign emitting = (state == DIGIT) || (state == SEP);
`endif

  // Combinational so a full FIFO blocks the write in the same cycle.
  assign o_fifo_wr = emitting & ~i_fifo_full;

  always_comb begin
    o_ascii = 8'h00;
    case (state)
      DIGIT:   o_ascii = dig_char;
      SEP:     o_ascii = SEP_CHAR;
`ifdef BCD_TX_CRLF_EN
      CR:      o_ascii = ASCII_CR;
      LF:      o_ascii = ASCII_LF;
`endif
      default: o_ascii = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      idx   <= '0;
      dig_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            dig_q <= i_digits;
            idx   <= IDX_W'(NDIG - 1);
            err_q <= 1'b0;
            state <= DIGIT;
          end else begin
            state <= IDLE;
          end
        end

        DIGIT: begin
          if (o_fifo_wr) begin
            if (dig_bad) err_q <= 1'b1;
            if (idx == '0) begin
`ifdef BCD_TX_CRLF_EN
              state <= CR;
`else
              state <= DONE;
`endif
            end else if (DP_MASK[idx]) begin
              // idx is decremented when the separator goes out.
              state <= SEP;
            end else begin
              idx <= idx - IDX_W'(1);
            end
          end
        end

        SEP: begin
          if (o_fifo_wr) begin
            idx   <= idx - IDX_W'(1);
            state <= DIGIT;
          end
        end

`ifdef BCD_TX_CRLF_EN
        CR: begin
          if (o_fifo_wr) state <= LF;
        end

        LF: begin
          if (o_fifo_wr) state <= DONE;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state != IDLE) && (state != DONE);
  assign o_done  = (state == DONE);
  assign o_err   = err_q;
  assign o_state = state;

endmodule

// File: tb/tb_bcd_ascii_frame_tx.sv
// tb_bcd_ascii_frame_tx: table-driven frames plus hand-written sequences for
// back-to-back start, mid-frame start and mid-frame reset. Expected characters
// come from a bench model of the frame format and are checked by a monitor
// against every FIFO write.
module tb_bcd_ascii_frame_tx;

  localparam int          NDIG     = 4;
  localparam logic [3:0]  DP_MASK  = 4'b1010;
  localparam logic [7:0]  SEP_CHAR = 8'h2E;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_digits = '0;
  logic        i_fifo_full = 1'b0;
  logic [7:0]  o_ascii;
  logic        o_fifo_wr;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  bcd_ascii_frame_tx #(
    .NDIG     (NDIG),
    .DP_MASK  (DP_MASK),
    .SEP_CHAR (SEP_CHAR)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_digits    (i_digits),
    .i_fifo_full (i_fifo_full),
    .o_ascii     (o_ascii),
    .o_fifo_wr   (o_fifo_wr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_state     (o_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the frame format: pushes expected characters, returns length and
  // whether any digit is invalid.
  task automatic push_frame(input logic [15:0] d, output int len, output logic err);
    logic [3:0] nib;
    len = 0;
    err = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nib = d[4*k +: 4];
      if (nib > 4'd9) begin
        exp_q.push_back(8'h3F);
        err = 1'b1;
      end else begin
        exp_q.push_back(8'h30 + {4'h0, nib});
      end
      len++;
      if (k != 0 && DP_MASK[k]) begin
        exp_q.push_back(SEP_CHAR);
        len++;
      end
    end
`ifdef BCD_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    len += 2;
`endif
  endtask

  // Monitor: every accepted write must match the head of the queue.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (i_fifo_full) check("wr_while_full", {31'b0, o_fifo_wr}, 32'd0);
      if (o_fifo_wr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0h want none (t=%0t)", o_ascii, $time);
        end else begin
          check("char", {24'b0, o_ascii}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entry: inside cycle 0 with i_start=1 and the frame already pushed.
  // Exit: at the falling edge of the DONE cycle (or after the time budget).
  task automatic frame_body(input int len, input logic exp_err, input logic [31:0] mask,
                            input logic mid_start, input logic chain,
                            input logic [15:0] chain_d, output int nlen, output logic nerr);
    int   exp_done;
    logic got;
    exp_done = len + 1 + $countones(mask);
    nlen = 0;
    nerr = 1'b0;
    got  = 1'b0;
    @(posedge clk); #1;
    i_start  = 1'b0;
    i_digits = 16'($urandom);
    for (int c = 1; c <= 64; c++) begin
      i_fifo_full = (c < 32) ? mask[c] : 1'b0;
      i_start     = mid_start && (c == 3);
      @(negedge clk);
      if (c == 1) begin
        check("busy_first", {31'b0, o_busy}, 32'd1);
        check("err_cleared", {31'b0, o_err}, 32'd0);
        check("wr_first", {31'b0, o_fifo_wr}, {31'b0, ~mask[1]});
      end
      if (o_done) begin
        got = 1'b1;
        check("done_cycle", c, exp_done);
        check("busy_done", {31'b0, o_busy}, 32'd0);
        check("err_flag", {31'b0, o_err}, {31'b0, exp_err});
        check("queue_empty", exp_q.size(), 32'd0);
        if (chain) begin
          i_digits = chain_d;
          i_start  = 1'b1;
          push_frame(chain_d, nlen, nerr);
        end
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no o_done want cycle %0d", exp_done);
    end
  endtask

  typedef struct {
    logic [15:0] digits;
    logic [31:0] full;
    logic        mid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   len;
    int   nlen;
    logic merr;
    logic nerr;

    vecs[0] = '{16'h4275, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 32'h0, 1'b0, 1'b0};
    vecs[2] = '{16'h9599, 32'h0, 1'b0, 1'b0};
    vecs[3] = '{16'h42C5, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{16'h4275, 32'b11100, 1'b0, 1'b0};  // full in cycles 2..4
    vecs[5] = '{16'h1234, 32'h0, 1'b1, 1'b0};       // start pulsed mid-frame
    for (int i = 6; i < 10; i++) begin
      vecs[i].digits = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      vecs[i].full    = 32'($urandom_range(0, 31)) << 1;  // cycles 1..5 only
      vecs[i].mid     = 1'b0;
      vecs[i].exp_err = 1'b0;
    end

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr", {31'b0, o_fifo_wr}, 32'd0);
    check("rst_ascii", {24'b0, o_ascii}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_done}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_state", {29'b0, o_state}, 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // table-driven frames
    for (int i = 0; i < 10; i++) begin
      i_digits = vecs[i].digits;
      i_start  = 1'b1;
      push_frame(vecs[i].digits, len, merr);
      frame_body(len, vecs[i].exp_err, vecs[i].full, vecs[i].mid, 1'b0, 16'h0, nlen, nerr);
      @(posedge clk); #1;
      i_start = 1'b0;
    end

    // back-to-back: start during DONE, one gap cycle, bad digit carried over
    i_digits = 16'h06A5;
    i_start  = 1'b1;
    push_frame(16'h06A5, len, merr);
    frame_body(len, 1'b1, 32'h0, 1'b0, 1'b1, 16'h8037, nlen, nerr);
    frame_body(nlen, nerr, 32'h0, 1'b0, 1'b0, 16'h0, len, merr);
    @(posedge clk); #1;
    i_start = 1'b0;

    // reset after three characters, with start and full in the same cycle
    i_digits = 16'h4275;
    i_start  = 1'b1;
    push_frame(16'h4275, len, merr);
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_queue", exp_q.size(), len - 3);
    i_reset     = 1'b1;
    i_start     = 1'b1;
    i_fifo_full = 1'b1;
    @(posedge clk); #1;
    i_reset     = 1'b0;
    i_start     = 1'b0;
    i_fifo_full = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_wr", {31'b0, o_fifo_wr}, 32'd0);
    check("rst_mid_busy", {31'b0, o_busy}, 32'd0);
    check("rst_mid_state", {29'b0, o_state}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_start_dropped", {31'b0, o_busy}, 32'd0);
    @(posedge clk); #1;

    // fresh complete frame after reset
    i_digits = 16'h4275;
    i_start  = 1'b1;
    push_frame(16'h4275, len, merr);
    frame_body(len, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, nlen, nerr);
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check("idle_after", {31'b0, o_busy | o_fifo_wr | o_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
